// File: rtl/pixel_stream_tagger_pkg.sv
// Shared tag encodings, frame-sequencer states and word width used by the tagger
// and the downstream sliding-window filter/operation blocks.
package pixel_stream_tagger_pkg;

  localparam int unsigned TAG_WIDTH   = 2;
  localparam int unsigned DATA_WIDTH  = 8 + TAG_WIDTH;
  localparam int unsigned FLUSH_LINES = 4;

  localparam logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0;
  localparam logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1;
  localparam logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2;
  localparam logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    REFRESH,
    ACTIVE,
    FLUSH,
    DONE,
    ABORT
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] tag_word(input logic [TAG_WIDTH-1:0] tag,
                                                     input logic [7:0] pixel);
    return {tag, pixel};
  endfunction

endpackage

// File: rtl/pixel_line_pingpong.sv
// Two 1024x8 line banks with full flags: the write side fills bank[wsel], the read
// side drains bank[rsel]; a completed fill or a free toggles the respective select.
module pixel_line_pingpong (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       wr_en,
  input  logic       wr_last,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       free,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_full,
  output logic       next_full,
  output logic       bank0_full
);

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  logic [1:0] full;
  logic       wsel;
  logic       rsel;
  logic       rd_bank;
  logic       fill_done;

  assign fill_done  = wr_en && wr_last;
  // The address issued alongside a free already belongs to the following line.
  assign rd_bank    = rsel ^ free;
  assign wr_full    = full[wsel];
  // A fill completing this very cycle counts, so a line that just made it is not an underrun.
  assign next_full  = full[~rsel] || (fill_done && (wsel != rsel));
  assign bank0_full = full[0];

  always_ff @(posedge clk) begin
    if (wr_en && !wsel) mem0[wr_addr] <= wr_data;
    if (wr_en && wsel)  mem1[wr_addr] <= wr_data;
    rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
    end else begin
      if (fill_done) begin
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
      if (free) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_tagger.sv
// Line-buffered pixel tagger feeding the sliding-window filter with a gap-free tagged
// stream. Optional PIXEL_TAGGER_TEST_PATTERN_EN adds pattern_sel ((col+row) pixels).
module pixel_stream_tagger
  import pixel_stream_tagger_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            image_width,
  input  logic [9:0]            image_height,
  input  logic                  start,
`ifdef PIXEL_TAGGER_TEST_PATTERN_EN
  input  logic                  pattern_sel,
`endif
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  refresh,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  state_t                state;
  state_t                state_nxt;
  logic [9:0]            w_q;
  logic [9:0]            h_q;
  logic [9:0]            wcol;
  logic [9:0]            wrow;
  logic [9:0]            col;
  logic [9:0]            row;
  logic [9:0]            rd_addr;
  logic [7:0]            rd_data;
  logic [7:0]            pixel;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  xfer;
  logic                  wr_last;
  logic                  clear;
  logic                  free;
  logic                  col_last;
  logic                  wr_full;
  logic                  next_full;
  logic                  bank0_full;

  assign col_last = (col == w_q - 10'd1);
  assign wr_last  = (wcol == w_q - 10'd1);
  assign s_ready  = (state == PRELOAD || state == REFRESH || state == ACTIVE)
                    && !wr_full && (wrow < h_q);
  assign xfer     = s_valid && s_ready;
  assign clear    = (state == IDLE && start) || (state == ABORT);
  assign busy     = (state != IDLE);

`ifdef PIXEL_TAGGER_TEST_PATTERN_EN
  assign pixel = pattern_sel ? 8'(col + row) : rd_data;
`else
  assign pixel = rd_data;
`endif

  pixel_line_pingpong u_banks (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (xfer),
    .wr_last    (wr_last),
    .wr_addr    (wcol),
    .wr_data    (s_data),
    .free       (free),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_full    (wr_full),
    .next_full  (next_full),
    .bank0_full (bank0_full)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wcol <= '0;
      wrow <= '0;
    end else if (xfer) begin
      if (wr_last) begin
        wcol <= '0;
        wrow <= wrow + 10'd1;
      end else begin
        wcol <= wcol + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      w_q        <= '0;
      h_q        <= '0;
      col        <= '0;
      row        <= '0;
      data_out   <= '0;
      refresh    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_out   <= data_nxt;
      refresh    <= (state == REFRESH);
      frame_done <= (state == DONE);
      if (state == IDLE && start) begin
        w_q      <= image_width;
        h_q      <= image_height;
        underrun <= 1'b0;
      end
      if (state == ABORT) underrun <= 1'b1;
      case (state)
        REFRESH: begin
          col <= '0;
          row <= '0;
        end
        // FLUSH reuses row as its flush-line counter, restarting from 0 after the last image line.
        ACTIVE, FLUSH: begin
          if (col_last) begin
            col <= '0;
            row <= (state == ACTIVE && row == h_q - 10'd1) ? '0 : row + 10'd1;
          end else begin
            col <= col + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = tag_word(INVALID_TAG, 8'h00);
    free      = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE:    if (start) state_nxt = PRELOAD;
      PRELOAD: if (bank0_full) state_nxt = REFRESH;
      REFRESH: state_nxt = ACTIVE;
      ACTIVE: begin
        data_nxt = tag_word((col == '0) ? DATA_TAG1 : DATA_TAG0, pixel);
        rd_addr  = col_last ? '0 : col + 10'd1;
        free     = col_last;
        if (col_last) begin
          if (row == h_q - 10'd1) state_nxt = FLUSH;
          else if (!next_full)    state_nxt = ABORT;
        end
      end
      FLUSH: begin
        if (col_last && row == 10'(FLUSH_LINES - 1)) begin
          data_nxt  = tag_word(DATA_END_TAG, 8'h00);
          state_nxt = DONE;
        end
      end
      DONE:  state_nxt = IDLE;
      ABORT: begin
        data_nxt  = tag_word(DATA_END_TAG, 8'h00);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_stream_tagger.sv
// Directed bench for pixel_stream_tagger; covers PIXEL_TAGGER_TEST_PATTERN_EN when defined.
`timescale 1ns/1ps
module tb_pixel_stream_tagger;
  import pixel_stream_tagger_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [9:0]            image_width;
  logic [9:0]            image_height;
  logic                  start;
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  refresh;
  logic                  busy;
  logic                  frame_done;
  logic                  underrun;
`ifdef PIXEL_TAGGER_TEST_PATTERN_EN
  logic                  pattern_sel;
`endif

  always #5 clk = ~clk;

  pixel_stream_tagger dut (
    .clk          (clk),
    .rst          (rst),
    .image_width  (image_width),
    .image_height (image_height),
    .start        (start),
`ifdef PIXEL_TAGGER_TEST_PATTERN_EN
    .pattern_sel  (pattern_sel),
`endif
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .data_out     (data_out),
    .refresh      (refresh),
    .busy         (busy),
    .frame_done   (frame_done),
    .underrun     (underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observations collected by run_frame
  int         cyc, n_xfer, n_refresh, refresh_cyc, first_cyc, last_cyc, n_flush0;
  int         n_end, end_cyc, n_done, done_cyc, n_stall, xfer_at8, rst_cyc;
  logic [9:0] end_word, post_rst_data;
  logic       end_underrun, busy_after_end, post_rst_busy, post_rst_ready, post_rst_underrun;
  logic       timed_out;
  logic [9:0] outq [$];

  // vmode: 0 continuous, 1 every other cycle, 2 s_valid stuck high.
  task automatic run_frame(input int w, input int h, input int vmode, input int start_at,
                           input int rst_at, input int max_cyc);
    int feed_idx;
    bit xfer_now, start_done, done_flag;
    feed_idx = 0; start_done = 0; done_flag = 0;
    cyc = 0; n_xfer = 0; n_refresh = 0; refresh_cyc = -1; first_cyc = -1; last_cyc = -1;
    n_flush0 = 0; n_end = 0; end_cyc = -1; n_done = 0; done_cyc = -1; n_stall = 0;
    xfer_at8 = -1; rst_cyc = -1; end_word = '0; end_underrun = 1'b0; busy_after_end = 1'b1;
    post_rst_data = '1; post_rst_busy = 1'b1; post_rst_ready = 1'b1; post_rst_underrun = 1'b1;
    timed_out = 1'b0;
    outq.delete();
    image_width = 10'(w); image_height = 10'(h);
    start = 1'b1; s_valid = 1'b0; s_data = '0;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = (vmode != 1);
    s_data = 8'd1;
    while (!done_flag) begin
      if (s_valid && !s_ready && busy && n_xfer < w * h) n_stall++;
      xfer_now = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (xfer_now) begin feed_idx++; n_xfer++; end
      if (refresh) begin n_refresh++; refresh_cyc = cyc; end
      if (frame_done) begin n_done++; done_cyc = cyc; end
      case (data_out[9:8])
        DATA_TAG0, DATA_TAG1: begin
          if (outq.size() == 0) first_cyc = cyc;
          outq.push_back(data_out);
          last_cyc = cyc;
          if (outq.size() == 8) xfer_at8 = n_xfer;
        end
        DATA_END_TAG: begin
          n_end++; end_cyc = cyc; end_word = data_out; end_underrun = underrun;
        end
        default: if (outq.size() > 0 && n_end == 0 && rst_cyc < 0) n_flush0++;
      endcase
      if (end_cyc >= 0 && cyc == end_cyc + 1) busy_after_end = busy;
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        post_rst_data = data_out; post_rst_busy = busy;
        post_rst_ready = s_ready; post_rst_underrun = underrun;
      end
      start = 1'b0; rst = 1'b0;
      if (start_at >= 0 && !start_done && outq.size() == start_at) begin
        start = 1'b1; start_done = 1;
      end
      if (rst_at >= 0 && rst_cyc < 0 && outq.size() == rst_at) begin
        rst = 1'b1; rst_cyc = cyc;
      end
      if (rst_cyc >= 0)    s_valid = 1'b0;
      else if (vmode == 1) s_valid = (cyc % 2 == 1) && (feed_idx < w * h);
      else if (vmode == 2) s_valid = 1'b1;
      else                 s_valid = (feed_idx < w * h);
      s_data = 8'(feed_idx + 1);
      if (end_cyc >= 0 && cyc >= end_cyc + 3) done_flag = 1;
      if (rst_cyc >= 0 && cyc >= rst_cyc + 30) done_flag = 1;
      if (cyc >= max_cyc) begin timed_out = 1'b1; done_flag = 1; end
    end
    s_valid = 1'b0; start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    image_width = 10'd4; image_height = 10'd3;
`ifdef PIXEL_TAGGER_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (data_out !== 10'h000) $display("FAIL reset_data_out: got %h want 000", data_out); else n_pass++;
    n_checks++; if (refresh !== 1'b0) $display("FAIL reset_refresh: got %b want 0", refresh); else n_pass++;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_without_start: busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_basic_frame();
    int bad; int bad_i; logic [9:0] exp, got_bad, exp_bad;
    run_frame(4, 3, 0, -1, -1, 300);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL basic_timeout: got %b want 0", timed_out); else n_pass++;
    n_checks++; if (n_refresh != 1) $display("FAIL basic_refresh_count: got %0d want 1", n_refresh); else n_pass++;
    n_checks++; if (first_cyc != refresh_cyc + 1) $display("FAIL basic_refresh_to_data: got %0d want %0d", first_cyc, refresh_cyc + 1); else n_pass++;
    n_checks++; if (outq.size() != 12) $display("FAIL basic_pixel_count: got %0d want 12", outq.size()); else n_pass++;
    n_checks++; if (last_cyc - first_cyc != 11) $display("FAIL basic_contiguous: span %0d want 11", last_cyc - first_cyc); else n_pass++;
    bad = 0; bad_i = -1; got_bad = '0; exp_bad = '0;
    for (int unsigned i = 0; i < outq.size(); i++) begin
      exp = {((i % 4) == 0) ? DATA_TAG1 : DATA_TAG0, 8'(i + 1)};
      if (outq[i] !== exp) begin
        if (bad == 0) begin bad_i = int'(i); got_bad = outq[i]; exp_bad = exp; end
        bad++;
      end
    end
    n_checks++; if (bad != 0) $display("FAIL basic_words: %0d bad, first idx %0d got %h want %h", bad, bad_i, got_bad, exp_bad); else n_pass++;
    n_checks++; if (n_flush0 != 15) $display("FAIL basic_flush_invalid: got %0d want 15", n_flush0); else n_pass++;
    n_checks++; if (end_cyc - last_cyc != 16) $display("FAIL basic_flush_length: got %0d want 16", end_cyc - last_cyc); else n_pass++;
    n_checks++; if (n_end != 1 || end_word !== 10'h300) $display("FAIL basic_end_tag: count %0d word %h want 1 300", n_end, end_word); else n_pass++;
    n_checks++; if (n_done != 1 || done_cyc != end_cyc + 1) $display("FAIL basic_frame_done: count %0d at %0d want 1 at %0d", n_done, done_cyc, end_cyc + 1); else n_pass++;
    n_checks++; if (end_underrun !== 1'b0) $display("FAIL basic_underrun: got %b want 0", end_underrun); else n_pass++;
    n_checks++; if (busy_after_end !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy_after_end); else n_pass++;
    n_checks++; if (n_xfer != 12) $display("FAIL basic_transfers: got %0d want 12", n_xfer); else n_pass++;
  endtask

  task automatic test_half_rate();
    run_frame(4, 3, 1, -1, -1, 300);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL half_timeout: got %b want 0", timed_out); else n_pass++;
    n_checks++; if (outq.size() != 4) $display("FAIL half_pixels_before_abort: got %0d want 4", outq.size()); else n_pass++;
    n_checks++; if (n_end != 1 || end_word !== 10'h300) $display("FAIL half_end_tag: count %0d word %h want 1 300", n_end, end_word); else n_pass++;
    n_checks++; if (end_cyc != last_cyc + 1) $display("FAIL half_abort_timing: got %0d want %0d", end_cyc, last_cyc + 1); else n_pass++;
    n_checks++; if (end_underrun !== 1'b1) $display("FAIL half_underrun: got %b want 1", end_underrun); else n_pass++;
    n_checks++; if (n_done != 0) $display("FAIL half_no_frame_done: got %0d want 0", n_done); else n_pass++;
    n_checks++; if (busy_after_end !== 1'b0) $display("FAIL half_busy_after: got %b want 0", busy_after_end); else n_pass++;
  endtask

  task automatic test_back_pressure();
    int bad; logic [9:0] exp;
    run_frame(8, 3, 2, -1, -1, 400);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL bp_timeout: got %b want 0", timed_out); else n_pass++;
    n_checks++; if (xfer_at8 != 16) $display("FAIL bp_transfers_before_free: got %0d want 16", xfer_at8); else n_pass++;
    n_checks++; if (n_stall != 2) $display("FAIL bp_ready_low_cycles: got %0d want 2", n_stall); else n_pass++;
    n_checks++; if (n_xfer != 24) $display("FAIL bp_total_transfers: got %0d want 24", n_xfer); else n_pass++;
    bad = 0;
    for (int unsigned i = 0; i < outq.size(); i++) begin
      exp = {((i % 8) == 0) ? DATA_TAG1 : DATA_TAG0, 8'(i + 1)};
      if (outq[i] !== exp) bad++;
    end
    n_checks++; if (outq.size() != 24 || bad != 0) $display("FAIL bp_words: size %0d bad %0d want 24 0", outq.size(), bad); else n_pass++;
    n_checks++; if (n_done != 1) $display("FAIL bp_frame_done: got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int bad; logic [9:0] exp;
    run_frame(4, 3, 0, 5, -1, 300);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL restart_timeout: got %b want 0", timed_out); else n_pass++;
    bad = 0;
    for (int unsigned i = 0; i < outq.size(); i++) begin
      exp = {((i % 4) == 0) ? DATA_TAG1 : DATA_TAG0, 8'(i + 1)};
      if (outq[i] !== exp) bad++;
    end
    n_checks++; if (outq.size() != 12 || bad != 0) $display("FAIL restart_words: size %0d bad %0d want 12 0", outq.size(), bad); else n_pass++;
    n_checks++; if (n_refresh != 1 || n_end != 1) $display("FAIL restart_refresh_end: %0d %0d want 1 1", n_refresh, n_end); else n_pass++;
    n_checks++; if (end_cyc - last_cyc != 16) $display("FAIL restart_flush_length: got %0d want 16", end_cyc - last_cyc); else n_pass++;
    n_checks++; if (n_done != 1) $display("FAIL restart_frame_done: got %0d want 1", n_done); else n_pass++;
    n_checks++; if (end_underrun !== 1'b0) $display("FAIL restart_underrun_cleared: got %b want 0", end_underrun); else n_pass++;
  endtask

  task automatic test_mid_reset();
    run_frame(4, 3, 0, -1, 6, 300);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timed_out); else n_pass++;
    n_checks++; if (post_rst_data !== 10'h000) $display("FAIL rst_data_out: got %h want 000", post_rst_data); else n_pass++;
    n_checks++; if (post_rst_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", post_rst_busy); else n_pass++;
    n_checks++; if (post_rst_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", post_rst_ready); else n_pass++;
    n_checks++; if (post_rst_underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", post_rst_underrun); else n_pass++;
    n_checks++; if (n_end != 0) $display("FAIL rst_no_end_tag: got %0d want 0", n_end); else n_pass++;
    n_checks++; if (outq.size() != 6 || n_done != 0) $display("FAIL rst_stream_stopped: words %0d done %0d want 6 0", outq.size(), n_done); else n_pass++;
    run_frame(4, 3, 0, -1, -1, 300);
    n_checks++; if (outq.size() != 12 || n_done != 1) $display("FAIL rst_recovery: words %0d done %0d want 12 1", outq.size(), n_done); else n_pass++;
  endtask

  task automatic test_max_width();
    int bad; int n_tag1; logic [9:0] exp;
    run_frame(1023, 1, 0, -1, -1, 8000);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL wide_timeout: got %b want 0", timed_out); else n_pass++;
    n_checks++; if (outq.size() != 1023) $display("FAIL wide_pixel_count: got %0d want 1023", outq.size()); else n_pass++;
    n_checks++; if (last_cyc - first_cyc != 1022) $display("FAIL wide_contiguous: span %0d want 1022", last_cyc - first_cyc); else n_pass++;
    bad = 0; n_tag1 = 0;
    for (int unsigned i = 0; i < outq.size(); i++) begin
      exp = {(i == 0) ? DATA_TAG1 : DATA_TAG0, 8'(i + 1)};
      if (outq[i] !== exp) bad++;
      if (outq[i][9:8] == DATA_TAG1) n_tag1++;
    end
    n_checks++; if (bad != 0) $display("FAIL wide_words: %0d bad words want 0", bad); else n_pass++;
    n_checks++; if (n_tag1 != 1) $display("FAIL wide_first_tags: got %0d want 1", n_tag1); else n_pass++;
    n_checks++; if (n_flush0 != 4091) $display("FAIL wide_flush_invalid: got %0d want 4091", n_flush0); else n_pass++;
    n_checks++; if (end_cyc - last_cyc != 4092) $display("FAIL wide_flush_length: got %0d want 4092", end_cyc - last_cyc); else n_pass++;
    n_checks++; if (n_done != 1 || n_end != 1) $display("FAIL wide_completion: done %0d end %0d want 1 1", n_done, n_end); else n_pass++;
  endtask

`ifdef PIXEL_TAGGER_TEST_PATTERN_EN
  task automatic test_pattern();
    int bad; logic [9:0] exp;
    pattern_sel = 1'b1;
    run_frame(4, 2, 0, -1, -1, 300);
    pattern_sel = 1'b0;
    bad = 0;
    for (int unsigned i = 0; i < outq.size(); i++) begin
      exp = {((i % 4) == 0) ? DATA_TAG1 : DATA_TAG0, 8'((i % 4) + (i / 4))};
      if (outq[i] !== exp) bad++;
    end
    n_checks++; if (outq.size() != 8 || bad != 0) $display("FAIL pattern_words: size %0d bad %0d want 8 0", outq.size(), bad); else n_pass++;
    n_checks++; if (n_done != 1 || timed_out !== 1'b0) $display("FAIL pattern_completion: done %0d timeout %b want 1 0", n_done, timed_out); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_half_rate();
    test_start_ignored();
    test_back_pressure();
    test_mid_reset();
    test_max_width();
`ifdef PIXEL_TAGGER_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
